instruction_decode_stage: RTL and testbench

//  Registered, parametrised instruction-decode stage between instruction memory and the register file and control unit.

---
 rtl/decode_pkg.sv | 28 ++
 rtl/instr_field_extract.sv | 49 ++++
 rtl/instruction_decode_stage.sv | 134 +++++++++++++
 tb/tb_instruction_decode_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared lane positions and the decoded-entry layout for the instruction decode stage.
package decode_pkg;

    localparam int OPC_LSB  = 24;
    localparam int DST_LSB  = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;
    localparam int OFF_LSB  = 16;
    localparam int IMM_LSB  = 0;

    // Widest PC the entry can carry; narrower PCs are zero-padded into it.
    localparam int PC_MAX_W = 64;

    typedef struct packed {
        logic [7:0]          opcode;
        logic [7:0]          dst;
        logic [7:0]          src1;
        logic [7:0]          src2;
        logic [7:0]          imm;
        logic [7:0]          offset;
        logic [PC_MAX_W-1:0] pc;
    } decoded_t;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input int lsb);
        return word[lsb +: 8];
    endfunction

endpackage

// File: rtl/instr_field_extract.sv
// Combinational split of an instruction word into raw byte lanes plus the
// extended immediate and the word-scaled, sign-extended branch offset.
module instr_field_extract
    import decode_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int PC_W         = 32,
    parameter int SIGN_EXT_IMM = 0
) (
    input  logic [31:0]       instr,
    input  logic [PC_W-1:0]   pc,
    output decoded_t          entry,
    output logic [DATA_W-1:0] imm_x,
    output logic [PC_W-1:0]   branch_offset
);

    logic imm_sign;

    assign imm_sign = (SIGN_EXT_IMM != 0) & instr[IMM_LSB + 7];

    always_comb begin
        entry              = '0;
        entry.opcode       = byte_lane(instr, OPC_LSB);
        entry.dst          = byte_lane(instr, DST_LSB);
        entry.src1         = byte_lane(instr, SRC1_LSB);
        entry.src2         = byte_lane(instr, SRC2_LSB);
        entry.imm          = byte_lane(instr, IMM_LSB);
        entry.offset       = byte_lane(instr, OFF_LSB);
        entry.pc[PC_W-1:0] = pc;
    end

    always_comb begin
        imm_x      = '0;
        imm_x[7:0] = byte_lane(instr, IMM_LSB);
        for (int i = 8; i < DATA_W; i++) begin
            imm_x[i] = imm_sign;
        end
    end

    // Offset counts instruction words; shift by two to get a byte offset.
    always_comb begin
        branch_offset      = '0;
        branch_offset[9:2] = byte_lane(instr, OFF_LSB);
        for (int i = 10; i < PC_W; i++) begin
            branch_offset[i] = instr[OFF_LSB + 7];
        end
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered decode stage: a 2-entry skid buffer of pre-decoded instructions
// between fetch and execute, with flush for taken branches. PC_W must be 10..64.
module instruction_decode_stage
    import decode_pkg::*;
#(
    parameter int REG_ADDR_W   = 3,
    parameter int DATA_W       = 8,
    parameter int PC_W         = 32,
    parameter int SIGN_EXT_IMM = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [31:0]           INSTRUCTION,
    input  logic [PC_W-1:0]       IN_PC,
    input  logic                  FLUSH,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [7:0]            OPCODE,
    output logic [REG_ADDR_W-1:0] WRITEREG,
    output logic [REG_ADDR_W-1:0] READREG1,
    output logic [REG_ADDR_W-1:0] READREG2,
    output logic [DATA_W-1:0]     IMMEDIATE_X,
    output logic [7:0]            OFFSET,
    output logic [PC_W-1:0]       BRANCH_OFFSET,
    output logic [PC_W-1:0]       OUT_PC,
    output logic [1:0]            OCCUPANCY
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and IN_READY depends only on
    // registered occupancy so there is no OUT_READY -> IN_READY path.

    decoded_t          dec_entry;
    logic [DATA_W-1:0] dec_imm_x;
    logic [PC_W-1:0]   dec_branch;

    decoded_t          entry_q    [2];
    decoded_t          entry_d    [2];
    logic [DATA_W-1:0] imm_x_q    [2];
    logic [DATA_W-1:0] imm_x_d    [2];
    logic [PC_W-1:0]   branch_q   [2];
    logic [PC_W-1:0]   branch_d   [2];

    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] occ_q,  occ_d;

    logic     push;
    logic     pop;
    decoded_t head;
    logic     unused_head;

    instr_field_extract #(
        .DATA_W       (DATA_W),
        .PC_W         (PC_W),
        .SIGN_EXT_IMM (SIGN_EXT_IMM)
    ) u_extract (
        .instr         (INSTRUCTION),
        .pc            (IN_PC),
        .entry         (dec_entry),
        .imm_x         (dec_imm_x),
        .branch_offset (dec_branch)
    );

    assign IN_READY  = (occ_q != 2'd2);
    assign OUT_VALID = (occ_q != 2'd0);
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;

    always_comb begin
        entry_d  = entry_q;
        imm_x_d  = imm_x_q;
        branch_d = branch_q;
        head_d   = head_q;
        tail_d   = tail_q;
        occ_d    = occ_q;
        if (FLUSH) begin
            // Stored data is left in place; only the bookkeeping is cleared.
            head_d = 1'b0;
            tail_d = 1'b0;
            occ_d  = 2'd0;
        end else begin
            if (push) begin
                entry_d[tail_q]  = dec_entry;
                imm_x_d[tail_q]  = dec_imm_x;
                branch_d[tail_q] = dec_branch;
                tail_d           = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            entry_q[0]  <= '0;
            entry_q[1]  <= '0;
            imm_x_q[0]  <= '0;
            imm_x_q[1]  <= '0;
            branch_q[0] <= '0;
            branch_q[1] <= '0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            entry_q  <= entry_d;
            imm_x_q  <= imm_x_d;
            branch_q <= branch_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
        end
    end

    assign head = entry_q[head_q];

    assign OPCODE        = head.opcode;
    assign WRITEREG      = head.dst[REG_ADDR_W-1:0];
    assign READREG1      = head.src1[REG_ADDR_W-1:0];
    assign READREG2      = head.src2[REG_ADDR_W-1:0];
    assign OFFSET        = head.offset;
    assign OUT_PC        = head.pc[PC_W-1:0];
    assign IMMEDIATE_X   = imm_x_q[head_q];
    assign BRANCH_OFFSET = branch_q[head_q];
    assign OCCUPANCY     = occ_q;

    // Raw immediate, upper register-lane bits and spare PC bits are not presented.
    assign unused_head = ^{head.imm, head.dst, head.src1, head.src2, head.pc};

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage with sign extension into a 16-bit immediate.
module tb_instruction_decode_stage;

    localparam int RW = 3;
    localparam int DW = 16;
    localparam int PW = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          IN_VALID;
    logic          IN_READY;
    logic [31:0]   INSTRUCTION;
    logic [PW-1:0] IN_PC;
    logic          FLUSH;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [7:0]    OPCODE;
    logic [RW-1:0] WRITEREG;
    logic [RW-1:0] READREG1;
    logic [RW-1:0] READREG2;
    logic [DW-1:0] IMMEDIATE_X;
    logic [7:0]    OFFSET;
    logic [PW-1:0] BRANCH_OFFSET;
    logic [PW-1:0] OUT_PC;
    logic [1:0]    OCCUPANCY;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PW-1:0] exp_q[$];

    instruction_decode_stage #(
        .REG_ADDR_W   (RW),
        .DATA_W       (DW),
        .PC_W         (PW),
        .SIGN_EXT_IMM (1)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IN_VALID      (IN_VALID),
        .IN_READY      (IN_READY),
        .INSTRUCTION   (INSTRUCTION),
        .IN_PC         (IN_PC),
        .FLUSH         (FLUSH),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY),
        .OPCODE        (OPCODE),
        .WRITEREG      (WRITEREG),
        .READREG1      (READREG1),
        .READREG2      (READREG2),
        .IMMEDIATE_X   (IMMEDIATE_X),
        .OFFSET        (OFFSET),
        .BRANCH_OFFSET (BRANCH_OFFSET),
        .OUT_PC        (OUT_PC),
        .OCCUPANCY     (OCCUPANCY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [PW-1:0] pc);
        IN_VALID    = v;
        INSTRUCTION = ins;
        IN_PC       = pc;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".occ"},      64'(OCCUPANCY), 64'd0);
        check({tag, ".out_vld"},  64'(OUT_VALID), 64'd0);
        check({tag, ".in_rdy"},   64'(IN_READY),  64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".opcode"}, 64'(OPCODE),        64'd0);
        check({tag, ".wr"},     64'(WRITEREG),      64'd0);
        check({tag, ".rd1"},    64'(READREG1),      64'd0);
        check({tag, ".rd2"},    64'(READREG2),      64'd0);
        check({tag, ".imm"},    64'(IMMEDIATE_X),   64'd0);
        check({tag, ".off"},    64'(OFFSET),        64'd0);
        check({tag, ".br"},     64'(BRANCH_OFFSET), 64'd0);
        check({tag, ".pc"},     64'(OUT_PC),        64'd0);
    endtask

    task automatic pop_check(input string tag);
        logic [PW-1:0] exp_pc;
        check({tag, ".vld"}, 64'(OUT_VALID), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp_pc = exp_q.pop_front();
            check({tag, ".pc"}, 64'(OUT_PC), 64'(exp_pc));
        end
        tick();
    endtask

    initial begin
        RESET     = 1'b1;
        FLUSH     = 1'b0;
        OUT_READY = 1'b0;
        drive(1'b0, 32'h0, '0);
        tick();
        tick();
        check_idle("rst");
        check_zero_outputs("rst");
        RESET = 1'b0;
        tick();

        // Single decode with one-cycle latency.
        OUT_READY = 1'b1;
        drive(1'b1, 32'h0205_03FE, 32'd4);
        tick();
        drive(1'b0, 32'h0, '0);
        check("dec.vld",    64'(OUT_VALID),     64'd1);
        check("dec.occ",    64'(OCCUPANCY),     64'd1);
        check("dec.opcode", 64'(OPCODE),        64'h02);
        check("dec.wr",     64'(WRITEREG),      64'd5);
        check("dec.rd1",    64'(READREG1),      64'd3);
        check("dec.rd2",    64'(READREG2),      64'd6);
        check("dec.imm",    64'(IMMEDIATE_X),   64'hFFFE);
        check("dec.off",    64'(OFFSET),        64'h05);
        check("dec.br",     64'(BRANCH_OFFSET), 64'h14);
        check("dec.pc",     64'(OUT_PC),        64'd4);
        tick();
        check_idle("dec_drain");

        // Negative offset, then push+pop at occupancy 1.
        drive(1'b1, 32'h10FD_0000, 32'd8);
        tick();
        check("neg.opcode", 64'(OPCODE),        64'h10);
        check("neg.br",     64'(BRANCH_OFFSET), 64'hFFFF_FFF4);
        check("neg.imm",    64'(IMMEDIATE_X),   64'h0000);
        drive(1'b1, 32'h1102_0081, 32'd12);
        tick();
        drive(1'b0, 32'h0, '0);
        check("sim.occ",  64'(OCCUPANCY),     64'd1);
        check("sim.pc",   64'(OUT_PC),        64'd12);
        check("pos.br",   64'(BRANCH_OFFSET), 64'h0000_0008);
        check("pos.imm",  64'(IMMEDIATE_X),   64'hFF81);
        check("sim.op",   64'(OPCODE),        64'h11);
        tick();
        check_idle("sim_drain");

        // Backpressure: fill, hold, offer a third word, then release.
        OUT_READY = 1'b0;
        drive(1'b1, 32'h2001_0203, 32'h20);
        tick();
        drive(1'b1, 32'h2104_0506, 32'h24);
        tick();
        drive(1'b1, 32'h22AA_AAAA, 32'h99);
        check("bp.occ",  64'(OCCUPANCY), 64'd2);
        check("bp.rdy",  64'(IN_READY),  64'd0);
        check("bp.pc",   64'(OUT_PC),    64'h20);
        check("bp.op",   64'(OPCODE),    64'h20);
        tick();
        drive(1'b0, 32'h0, '0);
        check("bp.hold_occ", 64'(OCCUPANCY), 64'd2);
        check("bp.hold_pc",  64'(OUT_PC),    64'h20);
        check("bp.hold_wr",  64'(WRITEREG),  64'd1);
        check("bp.hold_rd1", 64'(READREG1),  64'd2);
        check("bp.hold_rd2", 64'(READREG2),  64'd3);
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h24);
        OUT_READY = 1'b1;
        pop_check("bp.pop0");
        check("bp.occ_after1", 64'(OCCUPANCY), 64'd1);
        pop_check("bp.pop1");
        check_idle("bp_drain");

        // Flush from full with an offered word.
        OUT_READY = 1'b0;
        drive(1'b1, 32'h3000_0000, 32'h30);
        tick();
        drive(1'b1, 32'h3100_0000, 32'h34);
        tick();
        drive(1'b1, 32'h3F00_0000, 32'h3C);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        drive(1'b0, 32'h0, '0);
        check_idle("flush_full");
        tick();
        check_idle("flush_full_after");

        // Flush from occupancy 1 while IN_READY=1 and a word is offered.
        drive(1'b1, 32'h5000_0000, 32'h50);
        tick();
        drive(1'b1, 32'h5400_0000, 32'h54);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        drive(1'b0, 32'h0, '0);
        check_idle("flush_one");
        tick();
        check_idle("flush_one_after");

        // Pointers restart at slot 0 after a flush.
        OUT_READY = 1'b1;
        drive(1'b1, 32'h6003_0100, 32'h60);
        tick();
        drive(1'b0, 32'h0, '0);
        check("post.pc",  64'(OUT_PC), 64'h60);
        check("post.op",  64'(OPCODE), 64'h60);
        check("post.vld", 64'(OUT_VALID), 64'd1);
        tick();

        // Asynchronous reset in the middle of a cycle with live traffic.
        OUT_READY = 1'b0;
        drive(1'b1, 32'h7001_0101, 32'h70);
        tick();
        drive(1'b1, 32'h7102_0202, 32'h74);
        tick();
        drive(1'b1, 32'h7203_0303, 32'h78);
        #2;
        RESET = 1'b1;
        #1;
        check_idle("arst");
        check_zero_outputs("arst");
        tick();
        RESET = 1'b0;
        drive(1'b0, 32'h0, '0);
        tick();
        check_idle("arst_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
